pipelined_control_unit: RTL and testbench

// - Successor to the combinational decoder. Decodes opcode/func in ID, carries control through ID/EX, EX/MEM, MEM/WB registers.
// - Adds bubble insertion on flush, load-use hazard stall, illegal-opcode flag and explicit defaults for every control bit.
// - Sits between instruction fetch/ID and the datapath; the datapath consumes the ex_*/mem_*/wb_* bundles.

---
 rtl/pipelined_control_unit_if.sv | 43 ++++
 rtl/pipelined_control_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pipelined_control_unit_if.sv
// ID-side and datapath-side control bundle of the pipelined control unit.
// master = fetch/ID + datapath side, slave = the control unit.
interface pipelined_control_unit_if #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ALUOP_W = 3
);
    logic               id_valid;
    logic [5:0]         id_opcode;
    logic [5:0]         id_func;
    logic [REG_AW-1:0]  id_rs;
    logic [REG_AW-1:0]  id_rt;
    logic [REG_AW-1:0]  id_rd;
    logic               flush;
    logic               stall;
    logic               ex_valid;
    logic               ex_branch;
    logic               ex_alusrc1;
    logic [ALUOP_W-1:0] ex_aluop;
    logic [1:0]         ex_alusrc2;
    logic [1:0]         ex_jump;
    logic               mem_valid;
    logic               mem_read;
    logic               mem_write;
    logic               mem_byte;
    logic               wb_valid;
    logic               wb_regwrite;
    logic [REG_AW-1:0]  wb_dest;
    logic               illegal;

    modport master (
        output id_valid, id_opcode, id_func, id_rs, id_rt, id_rd, flush,
        input  stall, ex_valid, ex_branch, ex_alusrc1, ex_aluop, ex_alusrc2, ex_jump,
               mem_valid, mem_read, mem_write, mem_byte,
               wb_valid, wb_regwrite, wb_dest, illegal
    );

    modport slave (
        input  id_valid, id_opcode, id_func, id_rs, id_rt, id_rd, flush,
        output stall, ex_valid, ex_branch, ex_alusrc1, ex_aluop, ex_alusrc2, ex_jump,
               mem_valid, mem_read, mem_write, mem_byte,
               wb_valid, wb_regwrite, wb_dest, illegal
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers.
// Optional load-use stall generation enabled by defining HAZARD_DETECT_EN.
module pipelined_control_unit #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned RA_IDX  = 31
) (
    input  logic clk,
    input  logic rst,
    pipelined_control_unit_if.slave bus
);
    logic               w_branch;
    logic               w_alusrc1;
    logic [ALUOP_W-1:0] w_aluop;
    logic [1:0]         w_alusrc2;
    logic [1:0]         w_jump;
    logic               w_mem_read;
    logic               w_mem_write;
    logic               w_mem_byte;
    logic               w_regwrite;
    logic [REG_AW-1:0]  w_dest;
    logic               w_illegal;
    logic               w_reads_rt;
    logic               w_stall;
    logic               w_bubble;

    logic               r_ex_valid;
    logic               r_ex_branch;
    logic               r_ex_alusrc1;
    logic [ALUOP_W-1:0] r_ex_aluop;
    logic [1:0]         r_ex_alusrc2;
    logic [1:0]         r_ex_jump;
    logic               r_ex_mem_read;
    logic               r_ex_mem_write;
    logic               r_ex_mem_byte;
    logic               r_ex_regwrite;
    logic [REG_AW-1:0]  r_ex_dest;
    logic               r_ex_illegal;

    logic               r_mem_valid;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_mem_byte;
    logic               r_mem_regwrite;
    logic [REG_AW-1:0]  r_mem_dest;

    logic               r_wb_valid;
    logic               r_wb_regwrite;
    logic [REG_AW-1:0]  r_wb_dest;

    // ID-stage decode of opcode/func into the full control word
    always_comb begin
        w_branch    = 1'b0;
        w_alusrc1   = 1'b1;
        w_aluop     = '0;
        w_alusrc2   = 2'b00;
        w_jump      = 2'b00;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_byte  = 1'b0;
        w_regwrite  = 1'b0;
        w_dest      = '0;
        w_illegal   = 1'b0;
        w_reads_rt  = 1'b0;
        case (bus.id_opcode)
            6'h03: begin
                w_reads_rt = 1'b1;
                w_regwrite = 1'b1;
                w_dest     = bus.id_rd;
                case (bus.id_func)
                    6'h08: begin
                        w_jump     = 2'b10;
                        w_regwrite = 1'b0;
                    end
                    6'h21: begin
                        w_dest     = bus.id_rt;
                        w_mem_read = 1'b1;
                    end
                    6'h13: begin
                        w_mem_write = 1'b1;
                        w_regwrite  = 1'b0;
                    end
                    default: ;
                endcase
            end
            6'h02: w_jump = 2'b01;
            6'h07: begin
                w_jump     = 2'b01;
                w_regwrite = 1'b1;
                w_dest     = REG_AW'(RA_IDX);
                w_alusrc1  = 1'b0;
                w_alusrc2  = 2'b10;
                w_aluop    = ALUOP_W'(1);
            end
            6'h09, 6'h0c, 6'h0e, 6'h0f: begin
                w_regwrite = 1'b1;
                w_dest     = bus.id_rt;
                w_alusrc2  = 2'b01;
                case (bus.id_opcode)
                    6'h09:   w_aluop = ALUOP_W'(1);
                    6'h0c:   w_aluop = ALUOP_W'(3);
                    6'h0e:   w_aluop = ALUOP_W'(4);
                    default: w_aluop = ALUOP_W'(5);
                endcase
            end
            6'h04, 6'h05: begin
                w_reads_rt = 1'b1;
                w_branch   = 1'b1;
                w_aluop    = ALUOP_W'(2);
            end
            6'h12, 6'h22: begin
                w_aluop    = ALUOP_W'(1);
                w_alusrc2  = 2'b01;
                w_regwrite = 1'b1;
                w_dest     = bus.id_rt;
                w_mem_read = 1'b1;
                w_mem_byte = (bus.id_opcode == 6'h22);
            end
            6'h2b, 6'h28: begin
                w_reads_rt  = 1'b1;
                w_aluop     = ALUOP_W'(1);
                w_alusrc2   = 2'b01;
                w_mem_write = 1'b1;
                w_mem_byte  = (bus.id_opcode == 6'h28);
            end
            default: begin
                w_alusrc1 = 1'b0;
                w_illegal = 1'b1;
            end
        endcase
    end

`ifdef HAZARD_DETECT_EN
    // Load in EX whose destination is consumed by the instruction in ID
    assign w_stall = !rst && bus.id_valid && r_ex_valid && r_ex_mem_read &&
                     (r_ex_dest != '0) &&
                     ((r_ex_dest == bus.id_rs) || (w_reads_rt && (r_ex_dest == bus.id_rt)));
`else
    logic w_unused_hazard;
    assign w_unused_hazard = &{1'b0, w_reads_rt, bus.id_rs, bus.id_rt};
    assign w_stall         = 1'b0;
`endif

    assign w_bubble = !bus.id_valid || bus.flush || w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_branch    <= 1'b0;
            r_ex_alusrc1   <= 1'b0;
            r_ex_aluop     <= '0;
            r_ex_alusrc2   <= 2'b00;
            r_ex_jump      <= 2'b00;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_ex_mem_byte  <= 1'b0;
            r_ex_regwrite  <= 1'b0;
            r_ex_dest      <= '0;
            r_ex_illegal   <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_byte     <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_dest     <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_dest      <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_valid     <= 1'b0;
                r_ex_branch    <= 1'b0;
                r_ex_alusrc1   <= 1'b0;
                r_ex_aluop     <= '0;
                r_ex_alusrc2   <= 2'b00;
                r_ex_jump      <= 2'b00;
                r_ex_mem_read  <= 1'b0;
                r_ex_mem_write <= 1'b0;
                r_ex_mem_byte  <= 1'b0;
                r_ex_regwrite  <= 1'b0;
                r_ex_dest      <= '0;
                r_ex_illegal   <= 1'b0;
            end else begin
                r_ex_valid     <= 1'b1;
                r_ex_branch    <= w_branch;
                r_ex_alusrc1   <= w_alusrc1;
                r_ex_aluop     <= w_aluop;
                r_ex_alusrc2   <= w_alusrc2;
                r_ex_jump      <= w_jump;
                r_ex_mem_read  <= w_mem_read;
                r_ex_mem_write <= w_mem_write;
                r_ex_mem_byte  <= w_mem_byte;
                r_ex_regwrite  <= w_regwrite;
                r_ex_dest      <= w_dest;
                r_ex_illegal   <= w_illegal;
            end
            // MEM and WB always advance
            r_mem_valid    <= r_ex_valid;
            r_mem_read     <= r_ex_mem_read;
            r_mem_write    <= r_ex_mem_write;
            r_mem_byte     <= r_ex_mem_byte;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_dest     <= r_ex_dest;
            r_wb_valid     <= r_mem_valid;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_dest      <= r_mem_dest;
        end
    end

    assign bus.stall       = w_stall;
    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_branch   = r_ex_branch;
    assign bus.ex_alusrc1  = r_ex_alusrc1;
    assign bus.ex_aluop    = r_ex_aluop;
    assign bus.ex_alusrc2  = r_ex_alusrc2;
    assign bus.ex_jump     = r_ex_jump;
    assign bus.illegal     = r_ex_illegal;
    assign bus.mem_valid   = r_mem_valid;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_byte    = r_mem_byte;
    assign bus.wb_valid    = r_wb_valid;
    assign bus.wb_regwrite = r_wb_regwrite;
    assign bus.wb_dest     = r_wb_dest;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Testbench for pipelined_control_unit: directed + random instruction streams
// against a decode-table and stage-history reference model.
module tb_pipelined_control_unit;
    typedef struct packed {
        logic       valid;
        logic       branch;
        logic       alusrc1;
        logic [2:0] aluop;
        logic [1:0] alusrc2;
        logic [1:0] jump;
        logic       mrd;
        logic       mwr;
        logic       mbyte;
        logic       rw;
        logic [4:0] dest;
        logic       ill;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    ctl_t hist [3];   // [0]=EX, [1]=MEM, [2]=WB expected contents

    pipelined_control_unit_if #(.REG_AW(5), .ALUOP_W(3)) bus ();

    pipelined_control_unit #(.REG_AW(5), .ALUOP_W(3), .RA_IDX(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Control word straight from the instruction table
    function automatic ctl_t decode(input logic [5:0] op, input logic [5:0] fn,
                                    input logic [4:0] rt, input logic [4:0] rd);
        ctl_t c;
        c = '0;
        c.valid   = 1'b1;
        c.alusrc1 = 1'b1;
        case (op)
            6'h03: begin
                c.rw = 1'b1; c.dest = rd;
                if (fn == 6'h08)      begin c.jump = 2'b10; c.rw = 1'b0; end
                else if (fn == 6'h21) begin c.dest = rt; c.mrd = 1'b1; end
                else if (fn == 6'h13) begin c.mwr = 1'b1; c.rw = 1'b0; end
            end
            6'h02: c.jump = 2'b01;
            6'h07: begin
                c.jump = 2'b01; c.rw = 1'b1; c.dest = 5'd31;
                c.alusrc1 = 1'b0; c.alusrc2 = 2'b10; c.aluop = 3'd1;
            end
            6'h09, 6'h0c, 6'h0e, 6'h0f: begin
                c.rw = 1'b1; c.dest = rt; c.alusrc2 = 2'b01;
                c.aluop = (op == 6'h09) ? 3'd1 : (op == 6'h0c) ? 3'd3 : (op == 6'h0e) ? 3'd4 : 3'd5;
            end
            6'h04, 6'h05: begin c.aluop = 3'd2; c.branch = 1'b1; end
            6'h12, 6'h22: begin
                c.aluop = 3'd1; c.alusrc2 = 2'b01; c.rw = 1'b1; c.dest = rt;
                c.mrd = 1'b1; c.mbyte = (op == 6'h22);
            end
            6'h2b, 6'h28: begin
                c.aluop = 3'd1; c.alusrc2 = 2'b01; c.mwr = 1'b1; c.mbyte = (op == 6'h28);
            end
            default: begin c = '0; c.valid = 1'b1; c.ill = 1'b1; end
        endcase
        return c;
    endfunction

    function automatic logic exp_stall(input logic v, input logic [5:0] op,
                                       input logic [4:0] rs, input logic [4:0] rt);
        logic rrt, hz, ret;
        rrt = (op == 6'h03) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2b) || (op == 6'h28);
        hz  = !rst && v && hist[0].valid && hist[0].mrd && (hist[0].dest != 5'd0) &&
              ((hist[0].dest == rs) || (rrt && (hist[0].dest == rt)));
        ret = hz;
`ifndef HAZARD_DETECT_EN
        ret = 1'b0;
`endif
        return ret;
    endfunction

    task automatic check_outs();
        chk("ex_bundle",
            32'({bus.ex_valid, bus.ex_branch, bus.ex_alusrc1, bus.ex_aluop, bus.ex_alusrc2, bus.ex_jump}),
            32'({hist[0].valid, hist[0].branch, hist[0].alusrc1, hist[0].aluop, hist[0].alusrc2, hist[0].jump}));
        chk("illegal", 32'(bus.illegal), 32'(hist[0].ill));
        chk("mem_bundle", 32'({bus.mem_valid, bus.mem_read, bus.mem_write, bus.mem_byte}),
            32'({hist[1].valid, hist[1].mrd, hist[1].mwr, hist[1].mbyte}));
        chk("wb_bundle", 32'({bus.wb_valid, bus.wb_regwrite, bus.wb_dest}),
            32'({hist[2].valid, hist[2].rw, hist[2].dest}));
    endtask

    // One clock: check registered outputs, present ID, check stall, advance model
    task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic fl, output logic st);
        check_outs();
        bus.id_valid = v; bus.id_opcode = op; bus.id_func = fn;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.flush = fl;
        #1;
        st = exp_stall(v, op, rs, rt);
        chk("stall", 32'(bus.stall), 32'(st));
        @(posedge clk);
        if (rst) begin
            hist[0] = '0; hist[1] = '0; hist[2] = '0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = (!v || fl || st) ? ctl_t'('0) : decode(op, fn, rt, rd);
        end
        @(negedge clk);
    endtask

    // Present an instruction until it is accepted (bounded)
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic fl);
        logic st;
        int   n;
        n = 0;
        do begin
            step(1'b1, op, fn, rs, rt, rd, (n == 0) ? fl : 1'b0, st);
            n++;
        end while (st && n < 4);
    endtask

    task automatic idle(input int n);
        logic st;
        for (int i = 0; i < n; i++) step(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, st);
    endtask

    logic [5:0] ops [16] = '{6'h03, 6'h03, 6'h03, 6'h02, 6'h07, 6'h09, 6'h0c, 6'h0e,
                             6'h0f, 6'h04, 6'h05, 6'h12, 6'h22, 6'h2b, 6'h28, 6'h3f};
    logic [5:0] fns [4]  = '{6'h08, 6'h21, 6'h13, 6'h20};

    initial begin
        logic       st, v, fl;
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd;
        hist[0] = '0; hist[1] = '0; hist[2] = '0;
        bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_func = '0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs();
        rst = 1'b0;

        issue(6'h09, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);        // addi rt=5
        idle(3);
        issue(6'h07, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);        // jal
        idle(3);
        issue(6'h12, 6'h00, 5'd2, 5'd4, 5'd0, 1'b0);        // lw rt=4
        issue(6'h03, 6'h20, 5'd4, 5'd6, 5'd7, 1'b0);        // add rs=4
        issue(6'h12, 6'h00, 5'd2, 5'd0, 5'd0, 1'b0);        // lw rt=0
        issue(6'h03, 6'h20, 5'd0, 5'd0, 5'd7, 1'b0);        // add rs=0
        issue(6'h12, 6'h00, 5'd2, 5'd4, 5'd0, 1'b0);
        step(1'b1, 6'h03, 6'h20, 5'd4, 5'd6, 5'd7, 1'b1, st); // flush during stall
        issue(6'h03, 6'h20, 5'd4, 5'd6, 5'd7, 1'b0);
        issue(6'h3f, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);        // illegal
        idle(3);

        st = 1'b0;
        op = '0; fn = '0; rs = '0; rt = '0; rd = '0; v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!st) begin
                v  = ($urandom % 8) != 0;
                op = ops[$urandom % 16];
                if (op == 6'h3f) op = 6'($urandom);
                fn = fns[$urandom % 4];
                rs = 5'($urandom_range(0, 7));
                rt = 5'($urandom_range(0, 7));
                rd = 5'($urandom_range(0, 7));
            end
            fl = ($urandom % 10) == 0;
            step(v, op, fn, rs, rt, rd, fl, st);
        end

        // Reset with instructions in flight
        issue(6'h09, 6'h00, 5'd1, 5'd3, 5'd0, 1'b0);
        issue(6'h22, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
        issue(6'h07, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        rst = 1'b1;
        step(1'b1, 6'h12, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0, st);
        rst = 1'b0;
        issue(6'h0f, 6'h00, 5'd0, 5'd9, 5'd0, 1'b0);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
